// File: rtl/frog_game_if.sv
// Bundle between the game controller and the frog position stage.
// master: controller side (drives jump/reset_position); slave: position stage.
interface frog_game_if;
    logic [10:0] frogX;
    logic [10:0] frogY;
    logic        hit_car;
    logic        in_water;
    logic        on_gate;
    logic [10:0] gate_destX;
    logic [10:0] gate_destY;
    logic        reset_position;
    logic        jump;
    logic [10:0] jumptoX;
    logic [10:0] jumptoY;

    modport master (
        output reset_position, jump, jumptoX, jumptoY,
        input  frogX, frogY, hit_car, in_water, on_gate,
        input  gate_destX, gate_destY
    );

    modport slave (
        input  reset_position, jump, jumptoX, jumptoY,
        output frogX, frogY, hit_car, in_water, on_gate,
        output gate_destX, gate_destY
    );
endinterface

// File: rtl/frog_game_ctrl.sv
// Game-level FSM: lives, score, level, death/win freezes and gate jumps.
// Ports: CLK, RESET, timer_done, start_key, bus (frog_game_if.master),
//        lives, score, level, move_en, game_state.
module frog_game_ctrl #(
    parameter int START_LIVES   = 3,
    parameter int GOAL_Y        = 40,
    parameter int DEATH_FRAMES  = 32,
    parameter int WIN_FRAMES    = 64,
    parameter int GATE_COOLDOWN = 16,
    parameter int MAX_LEVEL     = 7
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             timer_done,
    input  logic             start_key,
    frog_game_if.master      bus,
    output logic [1:0]       lives,
    output logic [7:0]       score,
    output logic [2:0]       level,
    output logic             move_en,
    output logic [2:0]       game_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_DYING = 3'd2,
        S_WIN   = 3'd3,
        S_OVER  = 3'd4
    } state_e;

    localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);
    localparam logic [10:0] GOAL_LIM   = 11'(GOAL_Y);
    localparam logic [7:0]  DEATH_CNT  = 8'(DEATH_FRAMES);
    localparam logic [7:0]  WIN_CNT    = 8'(WIN_FRAMES);
    localparam logic [7:0]  GATE_CNT   = 8'(GATE_COOLDOWN);
    localparam logic [2:0]  LVL_MAX    = 3'(MAX_LEVEL);

    state_e      state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  score_q, score_d;
    logic [2:0]  level_q, level_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cool_q, cool_d;
    logic        rp_q, rp_d;
    logic        jump_q, jump_d;
    logic [10:0] jx_q, jx_d;
    logic [10:0] jy_q, jy_d;
    logic        move_en_q;
    logic        start_key_q;
    logic        start_edge;
    logic        died;
    logic        goal;

    // frogX is reserved for future bounds checks.
    logic unused_frog_x;
    assign unused_frog_x = ^bus.frogX;

    assign start_edge = start_key & ~start_key_q;
    assign died       = bus.hit_car | bus.in_water;
    assign goal       = bus.frogY <= GOAL_LIM;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        cool_d  = cool_q;
        rp_d    = 1'b0;
        jump_d  = 1'b0;
        jx_d    = jx_q;
        jy_d    = jy_q;
        // Gate is accepted when the cooldown expires on this very tick,
        // so a held gate re-fires exactly GATE_COOLDOWN ticks later.
        if (timer_done && cool_q != 8'd0) begin
            cool_d = cool_q - 8'd1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_PLAY;
                    lives_d = LIVES_INIT;
                    score_d = 8'd0;
                    level_d = 3'd0;
                    rp_d    = 1'b1;
                    cool_d  = 8'd0;
                end
            end
            S_PLAY: begin
                if (timer_done) begin
                    if (died) begin
                        if (lives_q > 2'd1) begin
                            lives_d = lives_q - 2'd1;
                            cnt_d   = DEATH_CNT;
                            state_d = S_DYING;
                        end else begin
                            lives_d = 2'd0;
                            state_d = S_OVER;
                        end
                    end else if (goal) begin
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                        if (level_q < LVL_MAX) level_d = level_q + 3'd1;
                        cnt_d   = WIN_CNT;
                        state_d = S_WIN;
                    end else if (bus.on_gate && cool_d == 8'd0) begin
                        jump_d = 1'b1;
                        jx_d   = bus.gate_destX;
                        jy_d   = bus.gate_destY;
                        cool_d = GATE_CNT;
                    end
                end
            end
            S_DYING, S_WIN: begin
                if (timer_done) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_PLAY;
                        rp_d    = 1'b1;
                        cool_d  = 8'd0;
                    end
                end
            end
            S_OVER: begin
                if (start_edge) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            lives_q     <= LIVES_INIT;
            score_q     <= 8'd0;
            level_q     <= 3'd0;
            cnt_q       <= 8'd0;
            cool_q      <= 8'd0;
            rp_q        <= 1'b0;
            jump_q      <= 1'b0;
            jx_q        <= 11'd0;
            jy_q        <= 11'd0;
            move_en_q   <= 1'b0;
            start_key_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            cool_q      <= cool_d;
            rp_q        <= rp_d;
            jump_q      <= jump_d;
            jx_q        <= jx_d;
            jy_q        <= jy_d;
            move_en_q   <= (state_d == S_PLAY);
            start_key_q <= start_key;
        end
    end

    assign bus.reset_position = rp_q;
    assign bus.jump           = jump_q;
    assign bus.jumptoX        = jx_q;
    assign bus.jumptoY        = jy_q;
    assign lives              = lives_q;
    assign score              = score_q;
    assign level              = level_q;
    assign move_en            = move_en_q;
    assign game_state         = state_q;
endmodule
